// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared defaults and fill-state encoding for the median column window
package median_pkg;

    localparam int PIX_W_DEF     = 8;
    localparam int IMG_WIDTH_DEF = 64;

    typedef enum logic [1:0] {
        FILL0  = 2'd0,
        FILL1  = 2'd1,
        STREAM = 2'd2
    } fill_state_t;

    // STREAM is absorbing; the fill states step forward once per completed line.
    function automatic fill_state_t next_fill_state(input fill_state_t s);
        case (s)
            FILL0:   return FILL1;
            FILL1:   return STREAM;
            default: return STREAM;
        endcase
    endfunction

endpackage

// File: rtl/median_line_buf.sv
// rtl/median_line_buf.sv - enable-gated delay line of DEPTH pixels
module median_line_buf #(
    parameter int DEPTH = 64,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Storage is intentionally unreset; the fill states hide stale contents.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/median_column_window.sv
// rtl/median_column_window.sv - three-row column extractor feeding the median column sorter
module median_column_window
    import median_pkg::*;
#(
    parameter int IMG_WIDTH = IMG_WIDTH_DEF,
    parameter int PIX_W     = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [PIX_W-1:0] x2_y1,
    output logic [PIX_W-1:0] x2_y0,
    output logic [PIX_W-1:0] x2_ym1,
    output logic             col_valid,
    output logic             eol
);

    localparam int CNT_W = $clog2(IMG_WIDTH);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_WIDTH - 1);

    logic [PIX_W-1:0] line_a_tap;
    logic [PIX_W-1:0] line_b_tap;
    logic [CNT_W-1:0] col_cnt;
    fill_state_t      state;

    median_line_buf #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_line_a (
        .clk  (clk),
        .en   (pix_valid),
        .din  (pix_in),
        .dout (line_a_tap)
    );

    median_line_buf #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_line_b (
        .clk  (clk),
        .en   (pix_valid),
        .din  (line_a_tap),
        .dout (line_b_tap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x2_y1     <= '0;
            x2_y0     <= '0;
            x2_ym1    <= '0;
            col_valid <= 1'b0;
            eol       <= 1'b0;
            col_cnt   <= '0;
            state     <= FILL0;
        end else if (pix_valid) begin
            x2_y1  <= pix_in;
            x2_y0  <= line_a_tap;
            x2_ym1 <= line_b_tap;
            if (sof) begin
                // A start-of-frame pixel is column 0 of a fresh fill.
                col_cnt   <= CNT_W'(1);
                state     <= FILL0;
                col_valid <= 1'b0;
                eol       <= 1'b0;
            end else begin
                col_valid <= (state == STREAM);
                eol       <= (state == STREAM) && (col_cnt == LAST_COL);
                if (col_cnt == LAST_COL) begin
                    col_cnt <= '0;
                    state   <= next_fill_state(state);
                end else begin
                    col_cnt <= col_cnt + CNT_W'(1);
                end
            end
        end else begin
            col_valid <= 1'b0;
            eol       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_median_column_window.sv
// tb/tb_median_column_window.sv - directed self-checking bench for median_column_window
module tb_median_column_window;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pix_in = '0;
    logic       pix_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] x2_y1, x2_y0, x2_ym1;
    logic       col_valid, eol;

    int n_vec = 0;
    int n_err = 0;

    median_column_window #(.IMG_WIDTH(W), .PIX_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .x2_y1     (x2_y1),
        .x2_y0     (x2_y0),
        .x2_ym1    (x2_ym1),
        .col_valid (col_valid),
        .eol       (eol)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] p, input logic s);
        @(negedge clk);
        pix_in    = p;
        sof       = s;
        pix_valid = 1'b1;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic idle(input logic s);
        @(negedge clk);
        pix_valid = 1'b0;
        sof       = s;
        @(posedge clk);
        #1;
        sof = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] e1, input logic [7:0] e0,
                       input logic [7:0] em1, input logic ecv, input logic eeol);
        n_vec++;
        assert ({x2_y1, x2_y0, x2_ym1, col_valid, eol} === {e1, e0, em1, ecv, eeol})
        else begin
            n_err++;
            $error("FAIL %s: got %h/%h/%h cv=%b eol=%b, expected %h/%h/%h cv=%b eol=%b",
                   tag, x2_y1, x2_y0, x2_ym1, col_valid, eol, e1, e0, em1, ecv, eeol);
        end
    endtask

    // Older taps are undefined while filling, so only the current-row pixel is compared.
    task automatic chk_fill(input string tag, input logic [7:0] e1);
        n_vec++;
        assert ({x2_y1, col_valid, eol} === {e1, 1'b0, 1'b0})
        else begin
            n_err++;
            $error("FAIL %s: got y1=%h cv=%b eol=%b, expected y1=%h cv=0 eol=0",
                   tag, x2_y1, col_valid, eol, e1);
        end
    endtask

    task automatic fill_two_rows(input string tag, input logic first_sof);
        for (int i = 0; i < 2 * W; i++) begin
            logic [7:0] p;
            p = 8'((i / W) * 16 + (i % W));
            send(p, (i == 0) && first_sof);
            chk_fill(tag, p);
        end
    endtask

    initial begin
        #12;
        chk("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        fill_two_rows("fill", 1'b1);
        send(8'h20, 1'b0); chk("first_col", 8'h20, 8'h10, 8'h00, 1'b1, 1'b0);
        send(8'h21, 1'b0); chk("col_21",    8'h21, 8'h11, 8'h01, 1'b1, 1'b0);
        idle(1'b0);        chk("stall0",    8'h21, 8'h11, 8'h01, 1'b0, 1'b0);
        idle(1'b1);        chk("stall1",    8'h21, 8'h11, 8'h01, 1'b0, 1'b0);
        idle(1'b0);        chk("stall2",    8'h21, 8'h11, 8'h01, 1'b0, 1'b0);
        send(8'h22, 1'b0); chk("after_stall", 8'h22, 8'h12, 8'h02, 1'b1, 1'b0);
        send(8'h23, 1'b0); chk("eol_23",    8'h23, 8'h13, 8'h03, 1'b1, 1'b1);

        for (int r = 3; r <= 6; r++) begin
            for (int c = 0; c < W; c++) begin
                logic [7:0] p;
                p = 8'(r * 16 + c);
                send(p, 1'b0);
                chk("wrap", p, p - 8'h10, p - 8'h20, 1'b1, c == W - 1);
            end
        end

        fill_two_rows("fill_f2", 1'b1);
        for (int c = 0; c < W; c++) begin
            logic [7:0] p;
            p = 8'(8'h20 + c);
            send(p, 1'b0);
            chk("f2_row2", p, p - 8'h10, p - 8'h20, 1'b1, c == W - 1);
        end
        send(8'h30, 1'b0); chk("f2_30", 8'h30, 8'h20, 8'h10, 1'b1, 1'b0);
        send(8'h31, 1'b0); chk("f2_31", 8'h31, 8'h21, 8'h11, 1'b1, 1'b0);

        fill_two_rows("midsof_fill", 1'b1);
        send(8'h20, 1'b0); chk("midsof_col", 8'h20, 8'h10, 8'h00, 1'b1, 1'b0);

        send(8'h21, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        fill_two_rows("refill", 1'b0);
        send(8'h20, 1'b0); chk("refill_col", 8'h20, 8'h10, 8'h00, 1'b1, 1'b0);
        send(8'h21, 1'b0); chk("refill_21",  8'h21, 8'h11, 8'h01, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
